ctrl_unit_pipe: RTL and testbench

CTRL_UNIT_PIPE -- requirements
Module: ctrl_unit_pipe

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/ctrl_unit_pipe_cond_check.sv | 34 +++
 rtl/ctrl_unit_pipe.sv | 143 ++++++++++++++
 tb/tb_ctrl_unit_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the control-unit pipeline: modes, opcodes, condition codes,
// ALU commands and the per-stage control bundle.
package ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_ALU = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_CS = 4'b0010,
    CC_CC = 4'b0011,
    CC_MI = 4'b0100,
    CC_PL = 4'b0101,
    CC_VS = 4'b0110,
    CC_VC = 4'b0111,
    CC_HI = 4'b1000,
    CC_LS = 4'b1001,
    CC_GE = 4'b1010,
    CC_LT = 4'b1011,
    CC_GT = 4'b1100,
    CC_LE = 4'b1101,
    CC_AL = 4'b1110,
    CC_NV = 4'b1111
  } cond_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_MOV = 4'd1,
    ALU_ADD = 4'd2,
    ALU_ADC = 4'd3,
    ALU_SUB = 4'd4,
    ALU_SBC = 4'd5,
    ALU_AND = 4'd6,
    ALU_ORR = 4'd7,
    ALU_EOR = 4'd8,
    ALU_MVN = 4'd9
  } alu_cmd_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       s_out;
    logic       b;
    logic       no_src;
    logic       illegal;
    logic       cond_pass;
  } ctrl_t;

endpackage

// File: rtl/ctrl_unit_pipe_cond_check.sv
// ARM condition-code evaluation against a {N,Z,C,V} flag set.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = nzcv;
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      default: pass = 1'b1;  // AL and 1111 both execute unconditionally
    endcase
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Instruction decode / control unit with condition gating, status register and a
// STAGES-deep output pipeline supporting stall and flush.
module ctrl_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned CMD_W     = 4,
  parameter int unsigned STAGES    = 1,
  parameter bit          SR_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       op_code,
  input  logic [1:0]       mode,
  input  logic             s_in,
  input  logic [3:0]       cond,
  input  logic             stall,
  input  logic             flush,
  input  logic             sr_wr_en,
  input  logic [3:0]       sr_in,
  output logic             out_valid,
  output logic [CMD_W-1:0] alu_cmd,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             s_out,
  output logic             b,
  output logic             no_src,
  output logic             illegal,
  output logic             cond_pass,
  output logic [3:0]       sr_q
);

  localparam int unsigned LAST = STAGES - 1;

  logic [3:0] nzcv_d;
  logic       pass;
  ctrl_t      dec_d;
  ctrl_t      stage_q [STAGES];

  assign nzcv_d = (SR_BYPASS && sr_wr_en) ? sr_in : sr_q;

  cond_check u_cond_check (
    .cond (cond),
    .nzcv (nzcv_d),
    .pass (pass)
  );

  always_comb begin
    dec_d           = '0;
    dec_d.valid     = 1'b1;
    dec_d.cond_pass = pass;
    case (mode)
      MODE_ALU: begin
        dec_d.wb_en = 1'b1;
        dec_d.s_out = s_in;
        case (op_code)
          OP_MOV: begin dec_d.alu_cmd = ALU_MOV; dec_d.no_src = 1'b1; end
          OP_MVN: begin dec_d.alu_cmd = ALU_MVN; dec_d.no_src = 1'b1; end
          OP_ADD: dec_d.alu_cmd = ALU_ADD;
          OP_ADC: dec_d.alu_cmd = ALU_ADC;
          OP_SUB: dec_d.alu_cmd = ALU_SUB;
          OP_SBC: dec_d.alu_cmd = ALU_SBC;
          OP_AND: dec_d.alu_cmd = ALU_AND;
          OP_ORR: dec_d.alu_cmd = ALU_ORR;
          OP_EOR: dec_d.alu_cmd = ALU_EOR;
          OP_CMP: begin dec_d.alu_cmd = ALU_SUB; dec_d.wb_en = 1'b0; dec_d.s_out = 1'b1; end
          OP_TST: begin dec_d.alu_cmd = ALU_AND; dec_d.wb_en = 1'b0; dec_d.s_out = 1'b1; end
          default: dec_d.illegal = 1'b1;
        endcase
      end
      MODE_MEM: begin
        if (op_code == OP_ADD) begin
          dec_d.alu_cmd  = ALU_ADD;
          dec_d.wb_en    = s_in;
          dec_d.mem_r_en = s_in;
          dec_d.mem_w_en = !s_in;
        end else begin
          dec_d.illegal = 1'b1;
        end
      end
      MODE_BR: begin
        dec_d.b      = 1'b1;
        dec_d.no_src = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase

    if (dec_d.illegal) begin
      dec_d.alu_cmd  = '0;
      dec_d.wb_en    = 1'b0;
      dec_d.mem_r_en = 1'b0;
      dec_d.mem_w_en = 1'b0;
      dec_d.s_out    = 1'b0;
      dec_d.b        = 1'b0;
      dec_d.no_src   = 1'b0;
    end

    // A failed condition suppresses side effects only; alu_cmd/illegal/no_src travel on
    if (!pass) begin
      dec_d.wb_en    = 1'b0;
      dec_d.mem_r_en = 1'b0;
      dec_d.mem_w_en = 1'b0;
      dec_d.s_out    = 1'b0;
      dec_d.b        = 1'b0;
    end

    if (!in_valid) begin
      dec_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (!stall) begin
      stage_q[0] <= dec_d;
      for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (sr_wr_en) begin
      sr_q <= sr_in;
    end
  end

  assign out_valid = stage_q[LAST].valid;
  assign alu_cmd   = CMD_W'(stage_q[LAST].alu_cmd);
  assign wb_en     = stage_q[LAST].wb_en;
  assign mem_r_en  = stage_q[LAST].mem_r_en;
  assign mem_w_en  = stage_q[LAST].mem_w_en;
  assign s_out     = stage_q[LAST].s_out;
  assign b         = stage_q[LAST].b;
  assign no_src    = stage_q[LAST].no_src;
  assign illegal   = stage_q[LAST].illegal;
  assign cond_pass = stage_q[LAST].cond_pass;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed scoreboard bench: a two-stage bypassing instance and a one-stage
// non-bypassing instance share stimulus; expectations come from a reference decode.
module tb_ctrl_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] op_code;
  logic [1:0] mode;
  logic       s_in;
  logic [3:0] cond;
  logic       stall;
  logic       flush;
  logic       sr_wr_en;
  logic [3:0] sr_in;

  logic       a_out_valid, a_wb_en, a_mem_r_en, a_mem_w_en, a_s_out, a_b, a_no_src, a_illegal, a_cond_pass;
  logic [3:0] a_alu_cmd, a_sr_q;
  logic       b_out_valid, b_wb_en, b_mem_r_en, b_mem_w_en, b_s_out, b_b, b_no_src, b_illegal, b_cond_pass;
  logic [3:0] b_alu_cmd, b_sr_q;

  logic [12:0] out_a, out_b;
  logic [12:0] qa[$];
  logic [12:0] qb[$];
  logic [3:0]  sr_m;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_unit_pipe #(.CMD_W(4), .STAGES(2), .SR_BYPASS(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_code(op_code), .mode(mode),
    .s_in(s_in), .cond(cond), .stall(stall), .flush(flush), .sr_wr_en(sr_wr_en),
    .sr_in(sr_in), .out_valid(a_out_valid), .alu_cmd(a_alu_cmd), .wb_en(a_wb_en),
    .mem_r_en(a_mem_r_en), .mem_w_en(a_mem_w_en), .s_out(a_s_out), .b(a_b),
    .no_src(a_no_src), .illegal(a_illegal), .cond_pass(a_cond_pass), .sr_q(a_sr_q)
  );

  ctrl_unit_pipe #(.CMD_W(4), .STAGES(1), .SR_BYPASS(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_code(op_code), .mode(mode),
    .s_in(s_in), .cond(cond), .stall(stall), .flush(flush), .sr_wr_en(sr_wr_en),
    .sr_in(sr_in), .out_valid(b_out_valid), .alu_cmd(b_alu_cmd), .wb_en(b_wb_en),
    .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en), .s_out(b_s_out), .b(b_b),
    .no_src(b_no_src), .illegal(b_illegal), .cond_pass(b_cond_pass), .sr_q(b_sr_q)
  );

  assign out_a = {a_out_valid, a_alu_cmd, a_wb_en, a_mem_r_en, a_mem_w_en, a_s_out, a_b, a_no_src, a_illegal, a_cond_pass};
  assign out_b = {b_out_valid, b_alu_cmd, b_wb_en, b_mem_r_en, b_mem_w_en, b_s_out, b_b, b_no_src, b_illegal, b_cond_pass};

  // ARM conditions come in true/inverted pairs; bit 0 selects the inversion
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'b000:  base = z;
      3'b001:  base = cy;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = cy & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
  endfunction

  function automatic logic [12:0] exp_out(input logic v, input logic [1:0] md, input logic [3:0] op,
                                          input logic s, input logic [3:0] c, input logic [3:0] f);
    logic [3:0] alu;
    logic wb, mr, mw, so, br, ns, ill, cp;
    if (!v) return '0;
    {alu, wb, mr, mw, so, br, ns, ill} = '0;
    cp = cond_ref(c, f);
    if (md == 2'b00) begin
      wb = 1'b1; so = s;
      case (op)
        4'b1101: begin alu = 4'd1; ns = 1'b1; end
        4'b1111: begin alu = 4'd9; ns = 1'b1; end
        4'b0100: alu = 4'd2;
        4'b0101: alu = 4'd3;
        4'b0010: alu = 4'd4;
        4'b0110: alu = 4'd5;
        4'b0000: alu = 4'd6;
        4'b1100: alu = 4'd7;
        4'b0001: alu = 4'd8;
        4'b1010: begin alu = 4'd4; wb = 1'b0; so = 1'b1; end
        4'b1000: begin alu = 4'd6; wb = 1'b0; so = 1'b1; end
        default: ill = 1'b1;
      endcase
    end else if (md == 2'b01) begin
      if (op == 4'b0100) begin
        alu = 4'd2; wb = s; mr = s; mw = ~s;
      end else ill = 1'b1;
    end else if (md == 2'b10) begin
      br = 1'b1; ns = 1'b1;
    end else ill = 1'b1;
    if (ill) {alu, wb, mr, mw, so, br, ns} = '0;
    if (!cp) {wb, mr, mw, so, br} = '0;
    return {1'b1, alu, wb, mr, mw, so, br, ns, ill, cp};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    qa.delete(); qb.delete();
    qa.push_back('0); qa.push_back('0);
    qb.push_back('0);
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] md, input logic [3:0] op,
                      input logic s, input logic [3:0] c, input logic st, input logic fl,
                      input logic we, input logic [3:0] sri);
    logic [12:0] ea, eb, tmp;
    in_valid = v; mode = md; op_code = op; s_in = s; cond = c;
    stall = st; flush = fl; sr_wr_en = we; sr_in = sri;
    ea = exp_out(v, md, op, s, c, we ? sri : sr_m);
    eb = exp_out(v, md, op, s, c, sr_m);
    @(posedge clk);
    #1;
    if (we) sr_m = sri;
    if (fl) begin
      foreach (qa[i]) qa[i] = '0;
      foreach (qb[i]) qb[i] = '0;
    end else if (!st) begin
      qa.push_back(ea); tmp = qa.pop_front();
      qb.push_back(eb); tmp = qb.pop_front();
    end
    chk({tag, "_a"}, out_a, qa[0]);
    chk({tag, "_b"}, out_b, qb[0]);
    chk({tag, "_sr"}, {9'b0, a_sr_q}, {9'b0, sr_m});
  endtask

  task automatic idle(input string tag, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(tag, 1'b0, 2'b00, 4'h0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    {in_valid, op_code, mode, s_in, cond, stall, flush, sr_wr_en, sr_in} = '0;
    sr_m = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", out_a, '0);
    chk("reset_b", out_b, '0);
    chk("reset_sr", {5'b0, a_sr_q, b_sr_q}, '0);
    rst_n = 1'b1;

    // two-stage latency for a plain ADD
    step("add", 1'b1, 2'b00, 4'b0100, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    idle("add_lat", 2);

    // memory load then store
    step("ldr", 1'b1, 2'b01, 4'b0100, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("str", 1'b1, 2'b01, 4'b0100, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("mem_bad", 1'b1, 2'b01, 4'b0010, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    idle("mem_drain", 2);

    // flag write in the same cycle as an EQ instruction: only the bypassing copy passes
    step("eq_bypass", 1'b1, 2'b00, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100);
    idle("eq_drain", 2);

    for (int i = 0; i < 16; i++)
      step("alu_op", 1'b1, 2'b00, 4'(i), 1'($urandom_range(0, 1)), 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);

    for (int i = 0; i < 16; i++)
      step("cond", 1'b1, 2'b00, 4'b1101, 1'b1, 4'(i), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
    idle("cond_drain", 2);

    step("mode11", 1'b1, 2'b11, 4'b0100, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("op1011", 1'b1, 2'b00, 4'b1011, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("branch", 1'b1, 2'b10, 4'b0000, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
    idle("ill_drain", 2);

    // stream, hold for two cycles while inputs change, then flush under stall
    step("s1", 1'b1, 2'b00, 4'b0010, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("s2", 1'b1, 2'b01, 4'b0100, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("s3", 1'b1, 2'b10, 4'b0000, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    step("stall1", 1'b1, 2'b00, 4'b1111, 1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 4'b1010);
    step("stall2", 1'b1, 2'b00, 4'b0001, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h0);
    step("flush", 1'b1, 2'b00, 4'b0001, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 4'h0);
    idle("post_flush", 2);

    // asynchronous reset between clock edges
    step("r1", 1'b1, 2'b00, 4'b1100, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 4'b1111);
    step("r2", 1'b1, 2'b01, 4'b0100, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", out_a, '0);
    chk("async_rst_b", out_b, '0);
    chk("async_rst_sr", {5'b0, a_sr_q, b_sr_q}, '0);
    sr_m = '0;
    clear_model();
    #2;
    rst_n = 1'b1;
    step("post_rst", 1'b1, 2'b00, 4'b0101, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    idle("post_rst_drain", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
